// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer with one shared shift-add/subtract datapath.
// Optional build macro MULDIV_ZERO_BYPASS_EN: zero operands finish in one cycle.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);
  // Handshake: EX holds start/op/operands while stall is high; result is valid
  // only in the cycle done is high, which is also the cycle stall drops.
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int CW = $clog2(XLEN);

  state_t state, state_nxt;
  logic [CW-1:0] count;
  logic [2:0] op_q;
  logic neg_q;
  logic [XLEN-1:0] opnd, hi, lo;

  logic is_div, sign_a, sign_b, a_zero, b_zero, ovf, accept, special, neg_in;
  logic [XLEN-1:0] mag_a, mag_b, special_val, fix_val, hi_nxt, lo_nxt;
  logic [XLEN:0] shifted;
  logic [XLEN+1:0] lhs, rhs, alu;
  logic [2*XLEN-1:0] prod, prod_neg;

  assign is_div = op[2];
  assign sign_a = rs1_val[XLEN-1] & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
  assign sign_b = rs2_val[XLEN-1] & (op == 3'b001 || op == 3'b100 || op == 3'b110);
  assign mag_a  = sign_a ? -rs1_val : rs1_val;
  assign mag_b  = sign_b ? -rs2_val : rs2_val;
  assign a_zero = (rs1_val == '0);
  assign b_zero = (rs2_val == '0);
  assign ovf    = (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_val);
  assign neg_in = (is_div && op[1]) ? sign_a : (sign_a ^ sign_b);
  assign accept = (state == IDLE) && start && !flush;

  always_comb begin
    special     = 1'b0;
    special_val = '0;
    if (is_div && b_zero) begin
      special     = 1'b1;
      special_val = op[1] ? rs1_val : '1;
    end else if ((op == 3'b100 || op == 3'b110) && ovf) begin
      special     = 1'b1;
      special_val = op[1] ? '0 : rs1_val;
    end
`ifdef MULDIV_ZERO_BYPASS_EN
    else if (!is_div && (a_zero || b_zero)) begin
      special = 1'b1;
    end else if (is_div && a_zero) begin
      special = 1'b1;
    end
`endif
  end

  // One adder: divide subtracts the divisor from the shifted remainder, multiply adds the multiplicand.
  always_comb begin
    shifted = {hi, lo[XLEN-1]};
    lhs     = op_q[2] ? {1'b0, shifted} : {2'b00, hi};
    rhs     = op_q[2] ? ~{2'b00, opnd} : (lo[0] ? {2'b00, opnd} : '0);
    alu     = lhs + rhs + {{(XLEN+1){1'b0}}, op_q[2]};
    if (op_q[2]) begin
      hi_nxt = alu[XLEN+1] ? shifted[XLEN-1:0] : alu[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], ~alu[XLEN+1]};
    end else begin
      hi_nxt = alu[XLEN:1];
      lo_nxt = {alu[0], lo[XLEN-1:1]};
    end
  end

  always_comb begin
    prod     = {hi, lo};
    prod_neg = -prod;
    fix_val  = '0;
    case (op_q)
      3'b000:                 fix_val = neg_q ? prod_neg[XLEN-1:0] : lo;
      3'b001, 3'b010, 3'b011: fix_val = neg_q ? prod_neg[2*XLEN-1:XLEN] : hi;
      3'b100, 3'b101:         fix_val = neg_q ? -lo : lo;
      default:                fix_val = neg_q ? -hi : hi;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : CALC;
      CALC:    if (count == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign stall     = accept || (state == CALC) || (state == FIX);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && special) begin
            result <= special_val;
          end else if (accept) begin
            op_q  <= op;
            neg_q <= neg_in;
            opnd  <= mag_b;
            lo    <= mag_a;
            hi    <= '0;
            count <= CW'(XLEN-1);
          end
        end
        CALC: begin
          hi <= hi_nxt;
          lo <= lo_nxt;
          if (count != '0) count <= count - 1'b1;
        end
        FIX: if (!flush) result <= fix_val;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
  logic        clk, rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1_val, rs2_val, result;
  logic        stall, busy, done;
  logic [1:0]  state_dbg;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .stall(stall), .busy(busy),
    .done(done), .result(result), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    model = '0;
    case (f)
      3'd0: begin up = ua * ub; model = up[31:0]; end
      3'd1: begin sp = sa * sb; model = sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); model = sp[63:32]; end
      3'd3: begin up = ua * ub; model = up[63:32]; end
      3'd4: begin
        if (b == 0) model = 32'hFFFF_FFFF;
        else begin sp = sa / sb; model = sp[31:0]; end
      end
      3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) model = a;
        else begin sp = sa % sb; model = sp[31:0]; end
      end
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_lat = 34;
    if (f[2] && b == 0) exp_lat = 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) exp_lat = 1;
`ifdef MULDIV_ZERO_BYPASS_EN
    if (!f[2] && (a == 0 || b == 0)) exp_lat = 1;
    if (f[2] && a == 0 && b != 0) exp_lat = 1;
`endif
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) pick = corners[$urandom_range(0, 4)];
    else pick = $urandom;
  endfunction

  // driver: start held until done; lat is the cycle of done relative to cycle 0 (-1 = timeout)
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output int lat, output logic [31:0] res, output int stall_err);
    @(negedge clk);
    start = 1'b1; op = f; rs1_val = a; rs2_val = b;
    lat = -1; res = 'x; stall_err = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (done) begin
        lat = k; res = result;
        if (stall !== 1'b0) stall_err++;
        break;
      end
      if (stall !== 1'b1) stall_err++;
      @(negedge clk);
      if (scramble) begin op = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; rs1_val = '0; rs2_val = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [13];
    logic [31:0] t_a [13], t_b [13], t_r [13];
    int lat, serr;
    logic [31:0] res;
    t_op = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6, 3'd0};
    t_a  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
             32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd0};
    t_b  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9};
    t_r  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
             32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0};
    for (int i = 0; i < 13; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 1'b0, lat, res, serr);
      checks++; if (res !== t_r[i]) begin errors++; $display("FAIL directed_result[%0d] got=%h exp=%h", i, res, t_r[i]); end
      checks++; if (lat !== exp_lat(t_op[i], t_a[i], t_b[i]))
        begin errors++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat(t_op[i], t_a[i], t_b[i])); end
      checks++; if (serr !== 0) begin errors++; $display("FAIL directed_stall[%0d] got=%0d bad cycles exp=0", i, serr); end
    end
  endtask

  task automatic test_random();
    int lat, serr, elat;
    logic [31:0] res, a, b, e;
    logic [2:0] f;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7)); a = pick(); b = pick();
      exp_q.push_back(model(f, a, b));
      elat = exp_lat(f, a, b);
      run_op(f, a, b, 1'($urandom_range(0, 1)), lat, res, serr);
      e = exp_q.pop_front();
      checks++; if (res !== e) begin errors++; $display("FAIL random_result[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, f, a, b, res, e); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL random_latency[%0d] got=%0d exp=%0d", i, lat, elat); end
      checks++; if (serr !== 0) begin errors++; $display("FAIL random_stall[%0d] got=%0d bad cycles exp=0", i, serr); end
    end
  endtask

  task automatic test_flush();
    int lat, serr, spurious;
    logic [31:0] res;
    run_op(3'd5, 32'd100, 32'd7, 1'b0, lat, res, serr);
    // flush a DIV in CALC at cycle 10
    spurious = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd4; rs1_val = 32'd1000; rs2_val = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      #1; if (done) spurious++;
      @(negedge clk);
    end
    start = 1'b0; flush = 1'b1;
    #1; if (done) spurious++;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_calc_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0 || spurious != 0) begin errors++; $display("FAIL flush_calc_done got=%b pulses=%0d exp=0", done, spurious); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL flush_calc_result got=%h exp=%h", result, 32'd14); end
    run_op(3'd0, 32'd3, 32'd4, 1'b0, lat, res, serr);
    checks++; if (res !== 32'd12) begin errors++; $display("FAIL flush_restart_result got=%h exp=%h", res, 32'd12); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL flush_restart_latency got=%0d exp=34", lat); end
    // flush together with start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0; rs1_val = 32'd5; rs2_val = 32'd6;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got=%b exp=0", stall); end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
    // flush in FIX (cycle 33) suppresses completion
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs1_val = 32'd50; rs2_val = 32'd5;
    repeat (33) @(negedge clk);
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_fix got done=%b busy=%b exp=0/0", done, busy); end
    checks++; if (result !== 32'd12) begin errors++; $display("FAIL flush_fix_result got=%h exp=%h", result, 32'd12); end
  endtask

  task automatic test_back_to_back();
    int lat, serr;
    logic [31:0] res;
    logic [2:0]  f [4];
    logic [31:0] a [4], b [4];
    f = '{3'd0, 3'd3, 3'd4, 3'd6};
    a = '{32'd6, 32'h0001_0000, 32'd9, 32'hFFFF_FFF7};
    b = '{32'd7, 32'h0003_0000, 32'd0, 32'd4};
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], a[i], b[i], 1'b0, lat, res, serr);
      checks++; if (res !== model(f[i], a[i], b[i])) begin errors++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i, res, model(f[i], a[i], b[i])); end
      checks++; if (lat !== exp_lat(f[i], a[i], b[i])) begin errors++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat(f[i], a[i], b[i])); end
    end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat, serr;
    logic [31:0] res;
    run_op(3'd0, 32'd11, 32'd13, 1'b0, lat, res, serr);
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs1_val = 32'd1234; rs2_val = 32'd5678;
    repeat (5) @(negedge clk);
    start = 1'b0; rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0)
      begin errors++; $display("FAIL reset_mid_ctrl got busy=%b done=%b stall=%b exp=0/0/0", busy, done, stall); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_mid_result got=%h exp=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, lat, res, serr);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_mid_recover got=%h exp=ffffffff", res); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
